// File: rtl/cam_mac_sequencer.sv
// cam_mac_sequencer: phase sequencer for the CAM floating-point MAC array.
// It walks the array through store, exponent add, Emax store/output,
// mantissa alignment and the partial-product loop. Every output comes
// straight from a flop, and the next-cycle values are computed in one place.
module cam_mac_sequencer #(
  parameter int EXP_W       = 8,
  parameter int MAN_W       = 8,
  parameter int SHIFT_STEPS = 10,
  parameter int PSUM_W      = 16,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             align_bypass,
  input  logic             stall,
  input  logic             abort,
  output logic [3:0]       state_ctrl,
  output logic [10:0]      phase,
  output logic [IDX_W-1:0] loop_idx,
  output logic [IDX_W-1:0] psum_idx,
  output logic             busy,
  output logic             start_ready,
  output logic             done
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'b0000,
    ST_STORE      = 4'b0001,
    ST_EXP_CS     = 4'b0010,
    ST_EXP_BIT    = 4'b0011,
    ST_STORE_EMAX = 4'b0100,
    ST_EMAX_ADD   = 4'b0101,
    ST_FIND       = 4'b0110,
    ST_SHIFT      = 4'b0111,
    ST_PMUL       = 4'b1000,
    ST_PSUM       = 4'b1001,
    ST_DONE       = 4'b1111
  } state_e;

  // Last value that each loop counter reaches before its phase group ends.
  localparam logic [IDX_W-1:0] EXP_LAST   = IDX_W'(EXP_W - 1);
  localparam logic [IDX_W-1:0] SHIFT_LAST = IDX_W'(SHIFT_STEPS - 1);
  localparam logic [IDX_W-1:0] MAN_LAST   = IDX_W'(MAN_W - 1);
  localparam logic [IDX_W-1:0] PSUM_LAST  = IDX_W'(PSUM_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  state_e           state_r;
  state_e           state_s;
  logic [IDX_W-1:0] loop_idx_r;
  logic [IDX_W-1:0] loop_idx_s;
  logic [IDX_W-1:0] psum_idx_r;
  logic [IDX_W-1:0] psum_idx_s;
  logic             bypass_r;
  logic             bypass_s;
  logic [10:0]      phase_r;
  logic             busy_r;
  logic             start_ready_r;
  logic             done_r;

  // Map a state to its one-hot strobe; the DONE code (1111) owns bit 10.
  function automatic logic [10:0] phase_of(input state_e s);
    logic [10:0] p;
    case (s)
      ST_IDLE:       p = 11'b000_0000_0001;
      ST_STORE:      p = 11'b000_0000_0010;
      ST_EXP_CS:     p = 11'b000_0000_0100;
      ST_EXP_BIT:    p = 11'b000_0000_1000;
      ST_STORE_EMAX: p = 11'b000_0001_0000;
      ST_EMAX_ADD:   p = 11'b000_0010_0000;
      ST_FIND:       p = 11'b000_0100_0000;
      ST_SHIFT:      p = 11'b000_1000_0000;
      ST_PMUL:       p = 11'b001_0000_0000;
      ST_PSUM:       p = 11'b010_0000_0000;
      ST_DONE:       p = 11'b100_0000_0000;
      default:       p = 11'b000_0000_0001;
    endcase
    return p;
  endfunction

  // Next state and loop counters; abort beats stall, and stall beats start.
  always_comb begin
    state_s    = state_r;
    loop_idx_s = loop_idx_r;
    psum_idx_s = psum_idx_r;
    bypass_s   = bypass_r;
    if (abort) begin
      state_s    = ST_IDLE;
      loop_idx_s = '0;
      psum_idx_s = '0;
    end else if (stall) begin
      state_s    = state_r;
      loop_idx_s = loop_idx_r;
      psum_idx_s = psum_idx_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s    = ST_STORE;
            bypass_s   = align_bypass;
            loop_idx_s = '0;
            psum_idx_s = '0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_STORE: begin
          state_s = ST_EXP_CS;
        end
        ST_EXP_CS: begin
          state_s    = ST_EXP_BIT;
          loop_idx_s = '0;
        end
        ST_EXP_BIT: begin
          if (loop_idx_r == EXP_LAST) begin
            state_s    = ST_STORE_EMAX;
            loop_idx_s = '0;
          end else begin
            loop_idx_s = loop_idx_r + IDX_ONE;
          end
        end
        ST_STORE_EMAX: begin
          state_s    = ST_EMAX_ADD;
          loop_idx_s = '0;
        end
        ST_EMAX_ADD: begin
          if (loop_idx_r == EXP_LAST) begin
            state_s    = bypass_r ? ST_PMUL : ST_FIND;
            loop_idx_s = '0;
          end else begin
            loop_idx_s = loop_idx_r + IDX_ONE;
          end
        end
        ST_FIND: begin
          // FIND and SHIFT of one alignment step share the same index.
          state_s = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (loop_idx_r == SHIFT_LAST) begin
            state_s    = ST_PMUL;
            loop_idx_s = '0;
          end else begin
            state_s    = ST_FIND;
            loop_idx_s = loop_idx_r + IDX_ONE;
          end
        end
        ST_PMUL: begin
          state_s    = ST_PSUM;
          psum_idx_s = '0;
        end
        ST_PSUM: begin
          if (psum_idx_r == PSUM_LAST) begin
            psum_idx_s = '0;
            if (loop_idx_r == MAN_LAST) begin
              state_s    = ST_DONE;
              loop_idx_s = '0;
            end else begin
              state_s    = ST_PMUL;
              loop_idx_s = loop_idx_r + IDX_ONE;
            end
          end else begin
            psum_idx_s = psum_idx_r + IDX_ONE;
          end
        end
        ST_DONE: begin
          loop_idx_s = '0;
          psum_idx_s = '0;
          if (start) begin
            state_s  = ST_STORE;
            bypass_s = align_bypass;
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          loop_idx_s = '0;
          psum_idx_s = '0;
        end
      endcase
    end
  end

  // Register the state, counters and all status outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      loop_idx_r    <= '0;
      psum_idx_r    <= '0;
      bypass_r      <= 1'b0;
      phase_r       <= 11'b000_0000_0001;
      busy_r        <= 1'b0;
      start_ready_r <= 1'b1;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      loop_idx_r    <= loop_idx_s;
      psum_idx_r    <= psum_idx_s;
      bypass_r      <= bypass_s;
      phase_r       <= phase_of(state_s);
      busy_r        <= (state_s != ST_IDLE);
      start_ready_r <= (state_s == ST_IDLE) || (state_s == ST_DONE);
      done_r        <= (state_s == ST_DONE);
    end
  end

  assign state_ctrl  = state_r;
  assign phase       = phase_r;
  assign loop_idx    = loop_idx_r;
  assign psum_idx    = psum_idx_r;
  assign busy        = busy_r;
  assign start_ready = start_ready_r;
  assign done        = done_r;

endmodule

// File: tb/tb_cam_mac_sequencer.sv
// Directed bench for cam_mac_sequencer at default parameters. Expected
// outputs come from a cycle-indexed schedule of one operation.
module tb_cam_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        align_bypass = 1'b0;
  logic        stall = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  state_ctrl;
  logic [10:0] phase;
  logic [4:0]  loop_idx;
  logic [4:0]  psum_idx;
  logic        busy;
  logic        start_ready;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  cam_mac_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .align_bypass (align_bypass),
    .stall        (stall),
    .abort        (abort),
    .state_ctrl   (state_ctrl),
    .phase        (phase),
    .loop_idx     (loop_idx),
    .psum_idx     (psum_idx),
    .busy         (busy),
    .start_ready  (start_ready),
    .done         (done)
  );

  always #5 clk = ~clk;

  // All observed outputs packed into one word for comparison.
  logic [31:0] obs;
  assign obs = {4'd0, state_ctrl, loop_idx, psum_idx, phase, busy, start_ready, done};

  // Expected outputs t cycles after start was accepted (t=1 is STORE).
  function automatic logic [31:0] expv(input int t, input bit bp);
    int          base;
    int          u;
    logic [3:0]  st;
    logic [4:0]  lp;
    logic [4:0]  ps;
    logic [10:0] ph;
    logic [10:0] one;
    st = 4'd0; lp = 5'd0; ps = 5'd0; one = 11'd1;
    base = bp ? 20 : 40;
    if (t == 1) st = 4'd1;
    else if (t == 2) st = 4'd2;
    else if (t >= 3 && t <= 10) begin st = 4'd3; lp = 5'(t - 3); end
    else if (t == 11) st = 4'd4;
    else if (t >= 12 && t <= 19) begin st = 4'd5; lp = 5'(t - 12); end
    else if (!bp && t >= 20 && t <= 39) begin
      st = (((t - 20) % 2) == 0) ? 4'd6 : 4'd7;
      lp = 5'((t - 20) / 2);
    end else if (t >= base && t < base + 136) begin
      u  = t - base;
      lp = 5'(u / 17);
      if ((u % 17) == 0) st = 4'd8;
      else begin st = 4'd9; ps = 5'((u % 17) - 1); end
    end else if (t == base + 136) st = 4'd15;
    else st = 4'd0;
    ph = (st == 4'd15) ? 11'h400 : (one << st);
    return {4'd0, st, lp, ps, ph, (st != 4'd0), (st == 4'd0 || st == 4'd15), (st == 4'd15)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Accept a start and follow the schedule up to relative cycle vend.
  task automatic run_op(input bit bp, input int vend, input string tag);
    start = 1'b1; align_bypass = bp;
    tick();
    start = 1'b0; align_bypass = 1'b0;
    check(tag, obs, expv(1, bp));
    for (int v = 2; v <= vend; v++) begin
      tick();
      check(tag, obs, expv(v, bp));
    end
  endtask

  int t0;
  int t1;

  initial begin
    // Reset held, then released while idle.
    tick();
    check("rst_hold", obs, expv(0, 1'b0));
    rst = 1'b0;
    tick();
    check("rst_idle", obs, expv(0, 1'b0));

    // Asynchronous reset in the middle of PSUM.
    run_op(1'b0, 45, "pre_rst");
    #2 rst = 1'b1;
    #1;
    check("rst_async", obs, expv(0, 1'b0));
    tick();
    rst = 1'b0;
    tick();
    check("rst_after", obs, expv(0, 1'b0));

    // Full run without bypass, including return to IDLE.
    t0 = cyc;
    run_op(1'b0, 176, "full");
    check("full_done_time", 32'(cyc - t0), 32'd176);
    tick();
    check("full_idle", obs, expv(177, 1'b0));

    // Bypass run.
    t0 = cyc;
    run_op(1'b1, 157, "bypass");
    check("bypass_len", 32'(cyc - t0), 32'd157);

    // Stall 5 cycles at EMAX_ADD loop_idx=3, then stall in DONE.
    t0 = cyc;
    run_op(1'b0, 15, "stall_pre");
    stall = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_hold", obs, expv(15, 1'b0));
    end
    stall = 1'b0;
    start = 1'b0;
    for (int v = 16; v <= 176; v++) begin
      tick();
      check("stall_post", obs, expv(v, 1'b0));
    end
    check("stall_done_time", 32'(cyc - t0), 32'd181);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_in_done", obs, expv(176, 1'b0));
    end
    stall = 1'b0;
    tick();
    check("done_to_idle", obs, expv(0, 1'b0));

    // Start while busy is ignored; abort+stall in FIND loop_idx=4.
    run_op(1'b0, 25, "abort_pre");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy_ign", obs, expv(26, 1'b0));
    for (int v = 27; v <= 28; v++) begin
      tick();
      check("abort_pre", obs, expv(v, 1'b0));
    end
    abort = 1'b1; stall = 1'b1;
    tick();
    abort = 1'b0; stall = 1'b0;
    check("abort", obs, expv(0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_idle", obs, expv(0, 1'b0));
    end

    // Back-to-back: start in DONE goes straight to STORE.
    run_op(1'b0, 176, "b2b_first");
    t1 = cyc;
    run_op(1'b0, 176, "b2b_second");
    check("b2b_gap", 32'(cyc - t1), 32'd176);

    // start+abort in DONE goes to IDLE; abort in IDLE does nothing.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_abort", obs, expv(0, 1'b0));
    tick();
    abort = 1'b0;
    check("abort_in_idle", obs, expv(0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
